// File: rtl/execute_mul_pipe_ctrl_pkg.sv
// Shared types for the execute-stage multiplier pipe: issue, writeback,
// feedback and commit packs plus the default pipeline depth.
package execute_mul_pipe_ctrl_pkg;

  localparam int DEF_MUL_LATENCY = 3;
  localparam int DATA_W          = 32;
  localparam int PHY_W           = 6;
  localparam int ROB_W           = 5;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'd0,
    MUL_OP_MULH   = 2'd1,
    MUL_OP_MULHSU = 2'd2,
    MUL_OP_MULHU  = 2'd3
  } mul_op_t;

  typedef enum logic [3:0] {
    EXC_INSTRUCTION_ADDRESS_MISALIGNED = 4'd0,
    EXC_INSTRUCTION_ACCESS_FAULT       = 4'd1,
    EXC_ILLEGAL_INSTRUCTION            = 4'd2,
    EXC_BREAKPOINT                     = 4'd3
  } exception_id_t;

  typedef struct packed {
    logic                 valid;
    logic [DATA_W-1:0]    pc;
    logic [ROB_W-1:0]     rob_id;
    mul_op_t              op;
    logic [DATA_W-1:0]    src1_value;
    logic [DATA_W-1:0]    src2_value;
    logic                 rd_enable;
    logic                 need_rename;
    logic [PHY_W-1:0]     rd_phy;
    logic                 has_exception;
    exception_id_t        exception_id;
    logic [DATA_W-1:0]    exception_value;
  } issue_execute_pack_t;

  typedef struct packed {
    logic                 valid;
    logic [DATA_W-1:0]    pc;
    logic [ROB_W-1:0]     rob_id;
    logic                 rd_enable;
    logic                 need_rename;
    logic [PHY_W-1:0]     rd_phy;
    logic [DATA_W-1:0]    rd_value;
    logic                 has_exception;
    exception_id_t        exception_id;
    logic [DATA_W-1:0]    exception_value;
  } execute_wb_pack_t;

  typedef struct packed {
    logic                 enable;
    logic [PHY_W-1:0]     phy_id;
    logic [DATA_W-1:0]    value;
  } execute_feedback_channel_t;

  typedef struct packed {
    logic                 enable;
    logic                 flush;
  } commit_feedback_pack_t;

endpackage

// File: rtl/execute_mul_pipe_ctrl_mul_core.sv
// Multiplier datapath: 33x33 signed product computed from the tag stage-0
// operands and carried through STAGES registers sharing one stage enable.
module execute_mul_pipe_ctrl_mul_core #(
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               en,
  input  logic signed [32:0] src_a,
  input  logic signed [32:0] src_b,
  output logic signed [63:0] product
);

  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic signed [63:0] prod_p [STAGES];

  // Low 64 bits of a 64x64 product equal the full 33x33 signed product.
  assign a_ext = {{31{src_a[32]}}, src_a};
  assign b_ext = {{31{src_b[32]}}, src_b};

  always_ff @(posedge clk) begin
    if (en) begin
      prod_p[0] <= a_ext * b_ext;
      for (int i = 1; i < STAGES; i++) begin
        prod_p[i] <= prod_p[i-1];
      end
    end
  end

  assign product = prod_p[STAGES-1];

endmodule

// File: rtl/execute_mul_pipe_ctrl.sv
// Multiplier pipe controller: tag pipeline, stall/flush handling, result select.
// Optional MUL_PIPE_PERF_COUNTER_EN adds busy/stall cycle counters.
module execute_mul_pipe_ctrl
  import execute_mul_pipe_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = DEF_MUL_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst,
  input  issue_execute_pack_t       issue_mul_fifo_data_out,
  input  logic                      issue_mul_fifo_data_out_valid,
  output logic                      issue_mul_fifo_pop,
  input  logic                      mul_wb_port_full,
  output execute_wb_pack_t          mul_wb_port_data_in,
  output logic                      mul_wb_port_we,
  output logic                      mul_wb_port_flush,
  output execute_feedback_channel_t mul_execute_channel_feedback_pack,
  input  commit_feedback_pack_t     commit_feedback_pack,
`ifdef MUL_PIPE_PERF_COUNTER_EN
  output logic [31:0]               mul_perf_busy_cycles,
  output logic [31:0]               mul_perf_stall_cycles,
`endif
  output logic                      mul_busy
);

  localparam int L = MUL_LATENCY;

  issue_execute_pack_t stage [L];
  logic [L-1:0]        stage_valid;
  logic                commit_flush;
  logic                advance;
  logic signed [32:0]  core_a;
  logic signed [32:0]  core_b;
  logic signed [63:0]  product;
  execute_wb_pack_t    wb_pack;
  issue_execute_pack_t last;

  function automatic logic [DATA_W-1:0] select_result(input mul_op_t op,
                                                      input logic [63:0] prod);
    return (op == MUL_OP_MUL) ? prod[31:0] : prod[63:32];
  endfunction

  assign commit_flush       = commit_feedback_pack.enable & commit_feedback_pack.flush;
  assign advance            = !(stage_valid[L-1] & mul_wb_port_full);
  assign issue_mul_fifo_pop = issue_mul_fifo_data_out_valid & advance & !commit_flush;
  assign mul_busy           = |stage_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_valid <= '0;
    end else if (commit_flush) begin
      stage_valid <= '0;
    end else if (advance) begin
      stage_valid <= {stage_valid[L-2:0], issue_mul_fifo_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      stage[0] <= issue_mul_fifo_data_out;
      for (int i = 1; i < L; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // Signedness of each operand depends on the high-half variant.
  assign core_a = {(stage[0].op == MUL_OP_MULH || stage[0].op == MUL_OP_MULHSU) & stage[0].src1_value[31],
                   stage[0].src1_value};
  assign core_b = {(stage[0].op == MUL_OP_MULH) & stage[0].src2_value[31], stage[0].src2_value};

  execute_mul_pipe_ctrl_mul_core #(
    .STAGES (L - 1)
  ) u_mul_core (
    .clk     (clk),
    .en      (advance),
    .src_a   (core_a),
    .src_b   (core_b),
    .product (product)
  );

  assign last = stage[L-1];

  always_comb begin
    wb_pack                 = '0;
    wb_pack.valid           = last.valid;
    wb_pack.pc              = last.pc;
    wb_pack.rob_id          = last.rob_id;
    wb_pack.rd_enable       = last.rd_enable;
    wb_pack.need_rename     = last.need_rename;
    wb_pack.rd_phy          = last.rd_phy;
    wb_pack.has_exception   = last.has_exception;
    wb_pack.exception_id    = last.exception_id;
    wb_pack.exception_value = last.exception_value;
    wb_pack.rd_value        = (last.valid && !last.has_exception) ?
                              select_result(last.op, product) : '0;
  end

  assign mul_wb_port_data_in = wb_pack;
  assign mul_wb_port_we      = stage_valid[L-1] & !mul_wb_port_full & !commit_flush;
  assign mul_wb_port_flush   = commit_flush | (!stage_valid[L-1] & !mul_wb_port_full);

  assign mul_execute_channel_feedback_pack.enable = mul_wb_port_we & wb_pack.valid &
                                                    !wb_pack.has_exception &
                                                    wb_pack.rd_enable & wb_pack.need_rename;
  assign mul_execute_channel_feedback_pack.phy_id = wb_pack.rd_phy;
  assign mul_execute_channel_feedback_pack.value  = wb_pack.rd_value;

`ifdef MUL_PIPE_PERF_COUNTER_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_perf_busy_cycles  <= '0;
      mul_perf_stall_cycles <= '0;
    end else begin
      if (mul_busy) mul_perf_busy_cycles <= mul_perf_busy_cycles + 32'd1;
      if (!advance) mul_perf_stall_cycles <= mul_perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_execute_mul_pipe_ctrl.sv
// Directed self-checking bench for execute_mul_pipe_ctrl (default latency 3).
module tb_execute_mul_pipe_ctrl;
  import execute_mul_pipe_ctrl_pkg::*;

  localparam int L = DEF_MUL_LATENCY;

  logic                      clk = 1'b0;
  logic                      rst;
  issue_execute_pack_t       fifo_data;
  logic                      fifo_valid;
  logic                      pop;
  logic                      wb_full;
  execute_wb_pack_t          wb_data;
  logic                      we;
  logic                      wb_flush;
  execute_feedback_channel_t fb;
  commit_feedback_pack_t     commit;
  logic                      busy;

  int tests = 0;
  int fails = 0;

  execute_mul_pipe_ctrl dut (
    .clk                               (clk),
    .rst                               (rst),
    .issue_mul_fifo_data_out           (fifo_data),
    .issue_mul_fifo_data_out_valid     (fifo_valid),
    .issue_mul_fifo_pop                (pop),
    .mul_wb_port_full                  (wb_full),
    .mul_wb_port_data_in               (wb_data),
    .mul_wb_port_we                    (we),
    .mul_wb_port_flush                 (wb_flush),
    .mul_execute_channel_feedback_pack (fb),
    .commit_feedback_pack              (commit),
    .mul_busy                          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic issue_execute_pack_t mk(input mul_op_t op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [5:0] phy);
    issue_execute_pack_t p;
    p             = '0;
    p.valid       = 1'b1;
    p.op          = op;
    p.src1_value  = a;
    p.src2_value  = b;
    p.rd_enable   = 1'b1;
    p.need_rename = 1'b1;
    p.rd_phy      = phy;
    return p;
  endfunction

  task automatic test_reset();
    rst = 1'b0; fifo_valid = 1'b0; fifo_data = '0; wb_full = 1'b0; commit = '0;
    #1;
    tests++; if (we !== 1'b0)       begin fails++; $display("FAIL reset_we got %b exp 0", we); end
    tests++; if (wb_flush !== 1'b1) begin fails++; $display("FAIL reset_flush got %b exp 1", wb_flush); end
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    tests++; if (we !== 1'b0)        begin fails++; $display("FAIL idle_we got %b exp 0", we); end
    tests++; if (wb_flush !== 1'b1)  begin fails++; $display("FAIL idle_flush got %b exp 1", wb_flush); end
    tests++; if (pop !== 1'b0)       begin fails++; $display("FAIL idle_pop got %b exp 0", pop); end
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL idle_busy got %b exp 0", busy); end
    tests++; if (fb.enable !== 1'b0) begin fails++; $display("FAIL idle_fb_en got %b exp 0", fb.enable); end
  endtask

  task automatic test_mul();
    @(posedge clk); #1;
    fifo_data = mk(MUL_OP_MUL, 32'd12, 32'd6, 6'd10); fifo_valid = 1'b1;
    #1;
    tests++; if (pop !== 1'b1) begin fails++; $display("FAIL mul_pop got %b exp 1", pop); end
    for (int c = 1; c <= L; c++) begin
      @(posedge clk); #1;
      fifo_valid = 1'b0;
      #1;
      if (c < L) begin
        tests++; if (we !== 1'b0) begin fails++; $display("FAIL mul_early_we cycle %0d got %b exp 0", c, we); end
      end else begin
        tests++; if (we !== 1'b1) begin fails++; $display("FAIL mul_we got %b exp 1", we); end
        tests++; if (wb_data.rd_value !== 32'd72) begin fails++; $display("FAIL mul_value got %0d exp 72", wb_data.rd_value); end
        tests++; if (fb.enable !== 1'b1) begin fails++; $display("FAIL mul_fb_en got %b exp 1", fb.enable); end
        tests++; if (fb.phy_id !== 6'd10) begin fails++; $display("FAIL mul_fb_phy got %0d exp 10", fb.phy_id); end
        tests++; if (fb.value !== 32'd72) begin fails++; $display("FAIL mul_fb_value got %0d exp 72", fb.value); end
      end
    end
  endtask

  task automatic test_high_variants();
    mul_op_t     ops [3];
    logic [31:0] exp_v [3];
    ops[0] = MUL_OP_MULH;   exp_v[0] = 32'hFFFF_FFFF;
    ops[1] = MUL_OP_MULHU;  exp_v[1] = 32'h0000_0001;
    ops[2] = MUL_OP_MULHSU; exp_v[2] = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      fifo_data = mk(ops[k], 32'hFFFF_FFFF, 32'd2, 6'd3); fifo_valid = 1'b1;
      @(posedge clk); #1;
      fifo_valid = 1'b0;
      repeat (L - 1) @(posedge clk);
      #2;
      tests++; if (we !== 1'b1 || wb_data.rd_value !== exp_v[k]) begin
        fails++; $display("FAIL high_op%0d we %b value %h exp we 1 value %h", k, we, wb_data.rd_value, exp_v[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got  = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      fifo_valid = (sent < 5);
      fifo_data  = mk(MUL_OP_MUL, 32'(sent + 1), 32'd10, 6'(20 + sent));
      wb_full    = (c == 4 || c == 5);
      #1;
      if (wb_full) begin
        tests++; if (pop !== 1'b0 || we !== 1'b0) begin
          fails++; $display("FAIL stall_cycle%0d pop %b we %b exp 0 0", c, pop, we);
        end
      end
      if (pop) sent++;
      if (we) begin
        tests++; if (got >= 5 || wb_data.rd_value !== 32'((got + 1) * 10) || wb_data.rd_phy !== 6'(20 + got)) begin
          fails++; $display("FAIL b2b_result%0d value %0d phy %0d exp %0d %0d", got, wb_data.rd_value,
                            wb_data.rd_phy, (got + 1) * 10, 20 + got);
        end
        got++;
      end
    end
    fifo_valid = 1'b0; wb_full = 1'b0;
    tests++; if (got !== 5) begin fails++; $display("FAIL b2b_count got %0d exp 5", got); end
  endtask

  task automatic test_exception();
    issue_execute_pack_t p;
    p = mk(MUL_OP_MUL, 32'd3, 32'd4, 6'd7);
    p.has_exception   = 1'b1;
    p.exception_id    = EXC_ILLEGAL_INSTRUCTION;
    p.exception_value = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    fifo_data = p; fifo_valid = 1'b1;
    @(posedge clk); #1;
    fifo_valid = 1'b0;
    repeat (L - 1) @(posedge clk);
    #2;
    tests++; if (we !== 1'b1) begin fails++; $display("FAIL exc_we got %b exp 1", we); end
    tests++; if (wb_data.has_exception !== 1'b1 || wb_data.exception_id !== EXC_ILLEGAL_INSTRUCTION ||
                 wb_data.exception_value !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL exc_fields got %b %0d %h exp 1 2 deadbeef", wb_data.has_exception,
                        wb_data.exception_id, wb_data.exception_value);
    end
    tests++; if (wb_data.rd_value !== 32'd0) begin fails++; $display("FAIL exc_value got %0d exp 0", wb_data.rd_value); end
    tests++; if (fb.enable !== 1'b0) begin fails++; $display("FAIL exc_fb_en got %b exp 0", fb.enable); end
  endtask

  task automatic test_flush();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      fifo_data = mk(MUL_OP_MUL, 32'(c + 2), 32'd5, 6'(30 + c)); fifo_valid = 1'b1;
    end
    @(posedge clk); #1;
    fifo_data = mk(MUL_OP_MUL, 32'd9, 32'd9, 6'd40); fifo_valid = 1'b1;
    commit.enable = 1'b1; commit.flush = 1'b1;
    #1;
    tests++; if (pop !== 1'b0 || we !== 1'b0 || fb.enable !== 1'b0) begin
      fails++; $display("FAIL flush_cycle pop %b we %b fb %b exp 0 0 0", pop, we, fb.enable);
    end
    tests++; if (wb_flush !== 1'b1) begin fails++; $display("FAIL flush_port got %b exp 1", wb_flush); end
    @(posedge clk); #1;
    commit = '0; fifo_valid = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy got %b exp 0", busy); end
    for (int c = 0; c < L + 2; c++) begin
      @(posedge clk); #2;
      tests++; if (we !== 1'b0) begin fails++; $display("FAIL flush_late_we cycle %0d got %b exp 0", c, we); end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      fifo_data = mk(MUL_OP_MUL, 32'd7, 32'd7, 6'd50); fifo_valid = 1'b1;
    end
    @(posedge clk); #1;
    fifo_valid = 1'b0; rst = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < L + 2; c++) begin
      @(posedge clk); #2;
      tests++; if (we !== 1'b0) begin fails++; $display("FAIL rstmid_we cycle %0d got %b exp 0", c, we); end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_high_variants();
    test_back_to_back();
    test_exception();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
